// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through channels 0..3, samples y on the last dwell cycle of each,
// and presents the 4-bit snapshot with a one-cycle valid strobe. MUX_SCAN_PARITY_EN adds a parity output.
//
// state | meaning
// IDLE  | sel parked at 0, waiting for start
// SCAN  | dwelling on channel sel, capturing y_in on the last dwell cycle
// DONE  | one cycle, snapshot just published (valid=1)
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic       y_in,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap_q, cap_d;
    logic [3:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sel_d = 2'd0;
                cnt_d = '0;
                if (start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                // stop outranks any capture or publish landing on the same edge
                if (stop) begin
                    state_d = ST_IDLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    cap_d[sel_q] = y_in;
                    if (sel_q == 2'd3) begin
                        state_d  = ST_DONE;
                        sample_d = {y_in, cap_q[2:0]};
                        valid_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d = ^{y_in, cap_q[2:0]};
`endif
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                sel_d = 2'd0;
                cnt_d = '0;
                if (stop)      state_d = ST_IDLE;
                else if (cont) state_d = ST_SCAN;
                else           state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            cap_q    <= 4'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign sel    = sel_q;
    assign sample = sample_q;
    assign valid  = valid_q;
    assign busy   = (state_q != ST_IDLE);
`ifdef MUX_SCAN_PARITY_EN
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: one DWELL=4 and one DWELL=1 instance,
// each driven by a mux model selecting a bit of a test pattern.
module tb_mux_scan_sequencer;

    typedef struct {
        logic [3:0] s;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic       start4, stop4, cont4, y4;
    logic [3:0] pat4;
    logic [1:0] sel4;
    logic [3:0] sample4;
    logic       valid4, busy4;

    logic       start1, stop1, cont1, y1;
    logic [3:0] pat1;
    logic [1:0] sel1;
    logic [3:0] sample1;
    logic       valid1, busy1;

`ifdef MUX_SCAN_PARITY_EN
    logic parity4, parity1;
`endif

    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y4 = pat4[sel4];
    assign y1 = pat1[sel1];

    mux_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(stop4), .cont(cont4), .y_in(y4),
        .sel(sel4), .sample(sample4), .valid(valid4), .busy(busy4)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity4)
`endif
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .cont(cont1), .y_in(y1),
        .sel(sel1), .sample(sample1), .valid(valid1), .busy(busy1)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity1)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid4) begin
            chk("valid4_expected", int'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("sample4", int'(sample4), int'(e.s));
                chk("valid4_cycle", cyc, e.cyc);
`ifdef MUX_SCAN_PARITY_EN
                chk("parity4", int'(parity4), int'(^e.s));
`endif
            end
        end
        if (valid1) begin
            chk("valid1_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sample1", int'(sample1), int'(e.s));
                chk("valid1_cycle", cyc, e.cyc);
`ifdef MUX_SCAN_PARITY_EN
                chk("parity1", int'(parity1), int'(^e.s));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        start4 = 1'b0; stop4 = 1'b0; cont4 = 1'b0; pat4 = 4'b0000;
        start1 = 1'b0; stop1 = 1'b0; cont1 = 1'b0; pat1 = 4'b0000;
        step(3);
        chk("rst_sel", int'(sel4), 0);
        chk("rst_sample", int'(sample4), 0);
        chk("rst_valid", int'(valid4), 0);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;
        step(1);

        // single shot, pattern 1010
        pat4 = 4'b1010; start4 = 1'b1;
        q4.push_back('{4'b1010, cyc + 1 + 16});
        step(1); start4 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            chk("t1_sel", int'(sel4), n / 4);
            chk("t1_busy", int'(busy4), 1);
            step(1);
        end
        step(1);
        chk("t1_busy_fall", int'(busy4), 0);
        chk("t1_sel_idle", int'(sel4), 0);

        // continuous, pattern switched in the DONE cycle, stop during second DONE
        cont4 = 1'b1; pat4 = 4'b1010; start4 = 1'b1;
        q4.push_back('{4'b1010, cyc + 17});
        q4.push_back('{4'b0110, cyc + 34});
        step(1); start4 = 1'b0;
        step(16);
        pat4 = 4'b0110;
        step(1);
        chk("t2_sel_rescan", int'(sel4), 0);
        chk("t2_busy_rescan", int'(busy4), 1);
        step(16);
        stop4 = 1'b1;
        step(1); stop4 = 1'b0; cont4 = 1'b0;
        chk("t2_busy_stop", int'(busy4), 0);
        chk("t2_sel_stop", int'(sel4), 0);
        chk("t2_sample_hold", int'(sample4), 6);

        // abort at E9, previous sample 1010
        pat4 = 4'b1010; start4 = 1'b1;
        q4.push_back('{4'b1010, cyc + 17});
        step(1); start4 = 1'b0;
        step(17);
        pat4 = 4'b0101; start4 = 1'b1;
        step(1); start4 = 1'b0;
        step(8);
        stop4 = 1'b1;
        step(1); stop4 = 1'b0;
        chk("t3_busy", int'(busy4), 0);
        chk("t3_sel", int'(sel4), 0);
        chk("t3_sample", int'(sample4), 10);
`ifdef MUX_SCAN_PARITY_EN
        chk("t3_parity_hold", int'(parity4), 0);
`endif
        step(20);
        pat4 = 4'b1011; start4 = 1'b1;
        q4.push_back('{4'b1011, cyc + 17});
        step(1); start4 = 1'b0;
        step(17);
        chk("t3_clean_sample", int'(sample4), 11);
        chk("t3_clean_busy", int'(busy4), 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("t3_parity_hold2", int'(parity4), 1);
`endif

        // reset at E6 mid-scan, start held during reset
        pat4 = 4'b1111; start4 = 1'b1;
        step(1); start4 = 1'b0;
        step(5);
        chk("t4_sel_pre", int'(sel4), 1);
        rst = 1'b1; start4 = 1'b1;
        step(1);
        chk("t4_sel", int'(sel4), 0);
        chk("t4_sample", int'(sample4), 0);
        chk("t4_valid", int'(valid4), 0);
        chk("t4_busy", int'(busy4), 0);
        step(2);
        chk("t4_busy_held", int'(busy4), 0);
        rst = 1'b0; start4 = 1'b0;
        step(2);
        chk("t4_busy_after", int'(busy4), 0);

        // DWELL=1, start re-pulsed while busy and in DONE
        pat1 = 4'b0001; start1 = 1'b1;
        q1.push_back('{4'b0001, cyc + 5});
        step(1); start1 = 1'b0;
        chk("t5_sel0", int'(sel1), 0);
        step(1);
        chk("t5_sel1", int'(sel1), 1);
        start1 = 1'b1;
        step(1); start1 = 1'b0;
        chk("t5_sel2", int'(sel1), 2);
        step(1);
        chk("t5_sel3", int'(sel1), 3);
        step(1);
        start1 = 1'b1;
        step(1); start1 = 1'b0;
        chk("t5_busy_done", int'(busy1), 0);
        chk("t5_sel_idle", int'(sel1), 0);
        step(3);
        chk("t5_busy_after", int'(busy1), 0);
        chk("t5_sample", int'(sample1), 1);

        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
